// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared register-file types and constants
package cpu_types_pkg;
    localparam int NREGS_DEFAULT  = 32;
    localparam int DATA_W_DEFAULT = 32;
    localparam int AW_DEFAULT     = $clog2(NREGS_DEFAULT);
    localparam int REG_ZERO       = 0;
    typedef logic [AW_DEFAULT-1:0]     regbits_t;
    typedef logic [DATA_W_DEFAULT-1:0] word_t;
endpackage

// File: rtl/register_file_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits with issue/clear/flush priority and rbusy lookup
module rf_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [NRD*AW-1:0] rsel,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] wsel,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_sel,
    input  logic              flush,
    output logic [NRD-1:0]    rbusy
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [NRD-1:0]   w_hit;
    // next busy vector: writebacks clear, issue sets (newer producer wins), flush clears all
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NWR; j++)
            if (wen[j] && wsel[j*AW +: AW] != AW'(REG_ZERO)) w_busy_nxt[wsel[j*AW +: AW]] = 1'b0;
        if (iss_en && iss_sel != AW'(REG_ZERO)) w_busy_nxt[iss_sel] = 1'b1;
        if (flush) w_busy_nxt = '0;
        w_busy_nxt[REG_ZERO] = 1'b0;
    end
    // busy state register; reset discards any same-cycle update
    always_ff @(posedge clk or posedge RST) begin
        if (RST) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end
    // a same-cycle writeback to the read register hides busy only when it is forwarded
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NRD; i++)
            for (int j = 0; j < NWR; j++)
                if (BYPASS != 0 && !RST && wen[j] && wsel[j*AW +: AW] == rsel[i*AW +: AW]) w_hit[i] = 1'b1;
    end
    // per-port busy lookup; busy[0] is constant zero so rsel==0 reads not-busy
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++) rbusy[i] = r_busy[rsel[i*AW +: AW]] && !w_hit[i];
    end
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with busy-bit scoreboard and optional write bypass
module register_file_sb
    import cpu_types_pkg::*;
#(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [NRD*AW-1:0]     rsel,
    output logic [NRD*DATA_W-1:0] rdat,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        wen,
    input  logic [NWR*AW-1:0]     wsel,
    input  logic [NWR*DATA_W-1:0] wdat,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_sel,
    input  logic                  flush
);
    logic [DATA_W-1:0] r_regs [NREGS];
    // storage; later ports overwrite earlier ones so the highest-index port wins
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wen[j] && wsel[j*AW +: AW] != AW'(REG_ZERO))
                    r_regs[wsel[j*AW +: AW]] <= wdat[j*DATA_W +: DATA_W];
        end
    end
    // read mux with optional forwarding of same-cycle write data, highest port last
    always_comb begin
        rdat = '0;
        for (int i = 0; i < NRD; i++) begin
            rdat[i*DATA_W +: DATA_W] = r_regs[rsel[i*AW +: AW]];
            for (int j = 0; j < NWR; j++)
                if (BYPASS != 0 && !RST && wen[j] && wsel[j*AW +: AW] == rsel[i*AW +: AW])
                    rdat[i*DATA_W +: DATA_W] = wdat[j*DATA_W +: DATA_W];
            if (rsel[i*AW +: AW] == AW'(REG_ZERO)) rdat[i*DATA_W +: DATA_W] = '0;
        end
    end
    rf_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk     (clk),
        .RST     (RST),
        .rsel    (rsel),
        .wen     (wen),
        .wsel    (wsel),
        .iss_en  (iss_en),
        .iss_sel (iss_sel),
        .flush   (flush),
        .rbusy   (rbusy)
    );
endmodule
